piso_shift_tx: RTL

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/emb_pkg.sv | 12 +
 rtl/piso_bit_counter.sv | 32 +++
 rtl/piso_shift_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/emb_pkg.sv
// Shared types and constants for the embedded serial blocks.
package emb_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } piso_state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the PISO transmitter: synchronous clear, count enable,
// terminal count when the last bit of a word is on the line.
module piso_bit_counter
    import emb_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    // One spare bit so the final increment to WIDTH never wraps.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tc = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word in IDLE, shifts it out
// one bit per cycle, then pulses done for one cycle before returning to IDLE.
module piso_shift_tx
    import emb_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    piso_state_e      state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shifted;
    logic             first_bit;
    logic             next_bit;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             cnt_tc;

    // first_bit is the output-end bit of an incoming word, next_bit the one
    // that reaches the output end after the current shift.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
            first_bit    = load_data[WIDTH-1];
            next_bit     = sreg_q[WIDTH-2];
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
            first_bit    = load_data[0];
            next_bit     = sreg_q[1];
        end
    end

    assign accept     = (state_q == StIdle) && load_valid;
    assign cnt_clear  = accept || (state_q == StDone);
    assign cnt_enable = (state_q == StShift);

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            load_ready <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_valid) begin
                        state_q    <= StShift;
                        sreg_q     <= load_data;
                        load_ready <= 1'b0;
                        sout_valid <= 1'b1;
                        sout       <= first_bit;
                    end
                end
                StShift: begin
                    sreg_q <= sreg_shifted;
                    if (cnt_tc) begin
                        state_q    <= StDone;
                        sout_valid <= 1'b0;
                        sout       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        sout <= next_bit;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state_q    <= StIdle;
                    sreg_q     <= '0;
                    load_ready <= 1'b1;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
